fnd_scan_ctrl: RTL and testbench



---
 rtl/fnd_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
// Multi-digit 7-segment scan controller: double-buffered digit data, one-hot commons with dead-time.
// Optional build macro LEADING_ZERO_BLANK_EN auto-blanks leading zero digits of the active buffer.
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS  = 6,
  parameter int DIV         = 50000,
  parameter int DEAD        = 4,
  parameter int COM_ACT_LOW = 0,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_num,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  output logic [NUM_DIGITS-1:0]   o_com,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_DEAD  = CNT_W'(DEAD);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] COM_OFF   = {NUM_DIGITS{COM_ACT_LOW != 0}};
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACT_LOW != 0}};
  localparam logic                  DP_OFF    = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT_0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  // Active-high segment pattern, bit6 = a ... bit0 = g.
  function automatic logic [6:0] decode_hex(input logic [3:0] num);
    case (num)
      4'h0:    decode_hex = 7'b1111110;
      4'h1:    decode_hex = 7'b0110000;
      4'h2:    decode_hex = 7'b1101101;
      4'h3:    decode_hex = 7'b1111001;
      4'h4:    decode_hex = 7'b0110011;
      4'h5:    decode_hex = 7'b1011011;
      4'h6:    decode_hex = 7'b1011111;
      4'h7:    decode_hex = 7'b1110000;
      4'h8:    decode_hex = 7'b1111111;
      4'h9:    decode_hex = 7'b1111011;
      4'hA:    decode_hex = 7'b1110111;
      4'hB:    decode_hex = 7'b0011111;
      4'hC:    decode_hex = 7'b1001110;
      4'hD:    decode_hex = 7'b0111101;
      4'hE:    decode_hex = 7'b1001111;
      4'hF:    decode_hex = 7'b1000111;
      default: decode_hex = 7'b0000000;
    endcase
  endfunction

  logic [CNT_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  pending_r;
  logic [4*NUM_DIGITS-1:0] sh_num_r, act_num_r;
  logic [NUM_DIGITS-1:0] sh_dp_r, act_dp_r, sh_blank_r, act_blank_r;
  logic [NUM_DIGITS-1:0] lz_blank_s, dark_s, com_s;
  logic                  tick_s, boundary_s, digit_dp_s, digit_dark_s, dp_s;
  logic [3:0]            digit_num_s;
  logic [6:0]            seg_s;

  assign tick_s     = (cnt_r == CNT_LAST);
  assign boundary_s = tick_s && (idx_r == IDX_LAST);

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; everything above the first significant digit goes dark.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    lz_blank_s = {NUM_DIGITS{1'b0}};
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      seen          = seen | (act_num_r[4*k +: 4] != 4'h0) | act_dp_r[k];
      lz_blank_s[k] = ~seen;
    end
  end
`else
  assign lz_blank_s = {NUM_DIGITS{1'b0}};
`endif

  assign dark_s = act_blank_r | lz_blank_s;

  always_comb begin
    digit_num_s  = act_num_r[{idx_r, 2'b00} +: 4];
    digit_dp_s   = act_dp_r[idx_r];
    digit_dark_s = dark_s[idx_r];
    if (cnt_r < CNT_DEAD) begin
      com_s = COM_OFF;
    end else begin
      com_s = (ONE_HOT_0 << idx_r) ^ COM_OFF;
    end
    // A dark digit still drives its common so the scan duty stays uniform.
    if (digit_dark_s) begin
      seg_s = SEG_OFF;
      dp_s  = DP_OFF;
    end else begin
      seg_s = decode_hex(digit_num_s) ^ SEG_OFF;
      dp_s  = digit_dp_s ^ DP_OFF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else begin
      cnt_r <= tick_s ? {CNT_W{1'b0}} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (tick_s) begin
        idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // A load on the frame boundary still hands the old shadow over; the new data waits a frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_r   <= 1'b0;
      sh_num_r    <= {(4*NUM_DIGITS){1'b0}};
      sh_dp_r     <= {NUM_DIGITS{1'b0}};
      sh_blank_r  <= {NUM_DIGITS{1'b1}};
      act_num_r   <= {(4*NUM_DIGITS){1'b0}};
      act_dp_r    <= {NUM_DIGITS{1'b0}};
      act_blank_r <= {NUM_DIGITS{1'b1}};
    end else begin
      if (boundary_s && pending_r) begin
        act_num_r   <= sh_num_r;
        act_dp_r    <= sh_dp_r;
        act_blank_r <= sh_blank_r;
      end
      if (i_load) begin
        sh_num_r   <= i_num;
        sh_dp_r    <= i_dp;
        sh_blank_r <= i_blank;
      end
      pending_r <= i_load | (pending_r & ~boundary_s);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_com   <= COM_OFF;
      o_seg   <= SEG_OFF;
      o_dp    <= DP_OFF;
      o_frame <= 1'b0;
    end else begin
      o_com   <= com_s;
      o_seg   <= seg_s;
      o_dp    <= dp_s;
      o_frame <= boundary_s & pending_r;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl (NUM_DIGITS=6, DIV=8, DEAD=2, active-high polarities).
// Per-cycle reference model works from elapsed cycles and digit arrays; table rows and corner sequences on top.
module tb_fnd_scan_ctrl;
  localparam int ND   = 6;
  localparam int DIV  = 8;
  localparam int DEAD = 2;
  localparam int FR   = ND * DIV;

  logic          i_clk = 1'b0;
  logic          i_rst, i_load;
  logic [23:0]   i_num;
  logic [5:0]    i_dp, i_blank;
  logic [5:0]    o_com;
  logic [6:0]    o_seg;
  logic          o_dp, o_frame;

  fnd_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DIV), .DEAD(DEAD), .COM_ACT_LOW(0), .SEG_ACT_LOW(0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_num(i_num), .i_dp(i_dp),
    .i_blank(i_blank), .o_com(o_com), .o_seg(o_seg), .o_dp(o_dp), .o_frame(o_frame)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] segtab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // reference model state
  int         t;
  bit         m_pend;
  logic [3:0] m_act_num [ND];
  logic [3:0] m_sh_num  [ND];
  logic       m_act_dp [ND], m_act_bl [ND], m_sh_dp [ND], m_sh_bl [ND];

  // table hook / counters
  bit          tab_on = 1'b0;
  logic [41:0] tab_segs;
  logic [5:0]  tab_dp;
  logic [6:0]  prev_seg;
  bit          prev_valid = 1'b0;
  int          frame_cnt = 0;
  int          dead_cnt = 0;

  typedef struct {
    logic [23:0] num;
    logic [5:0]  dp;
    logic [5:0]  blank;
    logic [41:0] segs;   // {d5,d4,d3,d2,d1,d0}
    logic [5:0]  exp_dp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic bit lz_dark(input int d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < ND; j++)
      if (m_act_num[j] != 4'h0 || m_act_dp[j]) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    t = 0;
    m_pend = 1'b0;
    for (int k = 0; k < ND; k++) begin
      m_act_num[k] = 4'h0; m_sh_num[k] = 4'h0;
      m_act_dp[k] = 1'b0;  m_sh_dp[k] = 1'b0;
      m_act_bl[k] = 1'b1;  m_sh_bl[k] = 1'b1;
    end
  endtask

  task automatic rst_cycle();
    i_rst = 1'b1; i_load = 1'b0;
    @(posedge i_clk);
    model_reset();
    #1;
    chk("rst_com", o_com, 0);
    chk("rst_seg", o_seg, 0);
    chk("rst_dp", o_dp, 0);
    chk("rst_frame", o_frame, 0);
    prev_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic cycle(input bit ld, input logic [23:0] num, input logic [5:0] dp, input logic [5:0] bl);
    int pos, dig;
    bit dark, bnd;
    logic [5:0] e_com;
    logic [6:0] e_seg;
    logic e_dp, e_fr;
    i_load = ld; i_num = num; i_dp = dp; i_blank = bl;
    @(posedge i_clk);
    pos   = t % DIV;
    dig   = (t / DIV) % ND;
    bnd   = (pos == DIV - 1) && (dig == ND - 1);
    e_com = (pos < DEAD) ? 6'b000000 : 6'(1 << dig);
    dark  = m_act_bl[dig] || lz_dark(dig);
    e_seg = dark ? 7'b0000000 : segtab[m_act_num[dig]];
    e_dp  = dark ? 1'b0 : m_act_dp[dig];
    e_fr  = bnd && m_pend;
    if (bnd && m_pend) begin
      m_act_num = m_sh_num; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl;
      m_pend = 1'b0;
    end
    if (ld) begin
      for (int k = 0; k < ND; k++) begin
        m_sh_num[k] = num[4*k +: 4]; m_sh_dp[k] = dp[k]; m_sh_bl[k] = bl[k];
      end
      m_pend = 1'b1;
    end
    t++;
    #1;
    chk("com", o_com, e_com);
    chk("seg", o_seg, e_seg);
    chk("dp", o_dp, e_dp);
    chk("frame", o_frame, e_fr);
    if (prev_valid && o_seg !== prev_seg) chk("seg_change_outside_dead", o_com, 0);
    prev_seg = o_seg; prev_valid = 1'b1;
    if (tab_on && o_com != 6'b0) begin
      for (int k = 0; k < ND; k++) begin
        if (o_com == 6'(1 << k)) begin
          chk("tab_seg", o_seg, tab_segs[7*k +: 7]);
          chk("tab_dp", o_dp, tab_dp[k]);
        end
      end
    end
    frame_cnt += int'(o_frame);
    dead_cnt  += int'(o_com == 6'b0);
    @(negedge i_clk);
    i_load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 24'h0, 6'h0, 6'h0);
  endtask

  task automatic wait_frame();
    int n;
    bit got;
    n = 0; got = 1'b0;
    while (!got && n < 2 * FR) begin
      cycle(1'b0, 24'h0, 6'h0, 6'h0);
      got = o_frame;
      n++;
    end
    chk("frame_seen", got, 1);
  endtask

  task automatic show_frame_at(input logic [41:0] segs);
    // assumes model t is at the start of a frame; samples mid-slot of each digit
    for (int i = 0; i < FR; i++) begin
      cycle(1'b0, 24'h0, 6'h0, 6'h0);
      if (i % DIV == 5) chk("frame_digit_seg", o_seg, segs[7*(i/DIV) +: 7]);
    end
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{24'h543210, 6'b000001, 6'b000000,
                {7'b1011011, 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110}, 6'b000001};
    vecs[1] = '{24'hFEDCBA, 6'b000000, 6'b000000,
                {7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110, 7'b0011111, 7'b1110111}, 6'b000000};
    vecs[2] = '{24'h987698, 6'b111111, 6'b100001,
                {7'b0000000, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1111011, 7'b0000000}, 6'b011110};
    vecs[3] = '{24'h000000, 6'b101010, 6'b000000,
                {6{7'b1111110}}, 6'b101010};

    i_rst = 1'b1; i_load = 1'b0; i_num = 24'h0; i_dp = 6'h0; i_blank = 6'h0;
    model_reset();
    @(negedge i_clk);
    for (int i = 0; i < 3; i++) rst_cycle();

    // one slot after release: everything dark
    idle(DIV);
    chk("post_reset_seg_dark", o_seg, 0);

    // table-driven frames
    for (int v = 0; v < 4; v++) begin
      cycle(1'b1, vecs[v].num, vecs[v].dp, vecs[v].blank);
      frame_cnt = 0;
      wait_frame();
      tab_segs = vecs[v].segs; tab_dp = vecs[v].exp_dp;
      tab_on = 1'b1;
      idle(FR);
      tab_on = 1'b0;
      chk("single_frame_pulse", frame_cnt, 1);
    end

    // dead-time: over one full frame, exactly DEAD dark-common cycles per slot
    dead_cnt = 0;
    idle(FR);
    chk("dead_cycles_per_frame", dead_cnt, ND * DEAD);

    // load collision on a frame boundary while a previous load is pending
    if (t % FR == FR - 1) idle(1);
    cycle(1'b1, 24'h222222, 6'h0, 6'h0);
    while (t % FR != FR - 1) idle(1);
    frame_cnt = 0;
    cycle(1'b1, 24'h111111, 6'h0, 6'h0);
    show_frame_at({6{7'b1101101}});
    show_frame_at({6{7'b0110000}});
    chk("collision_frame_pulses", frame_cnt, 2);

    // back-to-back loads: last one wins
    cycle(1'b1, 24'h333333, 6'h0, 6'h0);
    cycle(1'b1, 24'h777777, 6'h0, 6'h0);
    wait_frame();
    show_frame_at({6{7'b1110000}});

    // reset mid-frame discards pending shadow data
    while (t % FR != 0) idle(1);
    cycle(1'b1, 24'h444444, 6'h0, 6'h0);
    idle(10);
    rst_cycle();
    frame_cnt = 0;
    idle(2 * FR);
    chk("reset_discards_pending", frame_cnt, 0);

`ifdef LEADING_ZERO_BLANK_EN
    cycle(1'b1, 24'h000120, 6'h0, 6'h0);
    wait_frame();
    show_frame_at({7'b0, 7'b0, 7'b0, 7'b0110000, 7'b1101101, 7'b1111110});
    cycle(1'b1, 24'h000000, 6'h0, 6'h0);
    wait_frame();
    show_frame_at({7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b1111110});
`endif

    // randomized loads against the reference model
    for (int i = 0; i < 1500; i++) begin
      logic [23:0] rn;
      logic [5:0]  rd, rb;
      bit          ld;
      ld = ($urandom_range(0, 15) == 0);
      rn = 24'($urandom) >> (4 * $urandom_range(0, 6));
      rd = 6'($urandom & $urandom & $urandom);
      rb = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      cycle(ld, rn, rd, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
